pipe_reg_chain: RTL and testbench
=================================

Name: pipe_reg_chain

Overview:
Parametrised multi-stage pipeline register chain with valid/ready handshake, per-stage flush and bubble collapsing. It replaces the per-signal n-bit pipeline registers between CPU stages. One instance carries a packed stage payload (PC, instruction, control bits, operands) across DEPTH register stages. Hazard logic can stall via out_ready or kill in-flight instructions via flush_mask.

Parameters:
WIDTH, 64, payload width in bits (>=1)
DEPTH, 4, number of register stages (>=1)
CW, $clog2(DEPTH+1), width of occupancy count (derived, not overridden)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  upstream item present
in_ready  output  1  chain accepts input this cycle
in_data  input  WIDTH  upstream payload
out_valid  output  1  stage DEPTH-1 holds an item
out_ready  input  1  downstream accepts this cycle
out_data  output  WIDTH  payload of stage DEPTH-1
flush_mask  input  DEPTH  bit i kills the item currently in stage i
occupancy  output  CW  number of valid stages, registered
stall_cnt  output  32  perf counter (see Optional Feature)
bubble_cnt  output  32  perf counter (see Optional Feature)

Behaviour:
- Reset (rst=0, asynchronous): all stage valids v[i]=0; all stage data d[i]=0; occupancy=0; counters=0. As a result, out_valid=0 and out_data=0.
- Stage 0 is the input side. Stage DEPTH-1 drives out_valid=v[DEPTH-1] and out_data=d[DEPTH-1].
- Ready chain (combinational):
  - rdy[DEPTH-1] = out_ready | ~v[DEPTH-1]
  - rdy[i] = rdy[i+1] | ~v[i]
  - in_ready = rdy[0]
- Ready uses pre-flush valids. A flush does not raise ready in the same cycle.
- Load rule, per stage i with predecessor p:
  - For i=0: v_src=in_valid, d_src=in_data. For i>0: v_src = v[i-1] & ~flush_mask[i-1], d_src = d[i-1].
  - If rdy[i]: v[i] <= v_src. If v_src is also 1, d[i] <= d_src; otherwise d[i] holds.
  - If ~rdy[i]: v[i] <= v[i] & ~flush_mask[i], and d[i] holds.
- Flush kills the item in stage i whether the item is moving or held. An item entering stage i in the same cycle is not affected by flush_mask[i].
- Bubble collapsing: an empty stage always loads, even when downstream is stalled. Items compact toward the output under back-pressure.
- Latency: on an empty chain with out_ready=1, an item accepted at edge k shows out_valid=1 after edge k+DEPTH-1. Throughput is 1 item/cycle.
- Order is preserved. No item is duplicated or dropped unless flushed.
- occupancy <= popcount of next-state v, so it is updated the same edge as v. Its range is 0..DEPTH.
- Simultaneous in_valid and full chain with out_ready=1: accept and emit in the same cycle; occupancy unchanged.
- out_ready=0 with full chain: in_ready=0 and all state holds, except bits cleared by flush_mask.
- Reset asserted mid-operation: all in-flight items are discarded immediately.
- DEPTH=1: single register with the same rules.

Optional Feature:
- Macro: PIPE_REG_CHAIN_PERF_EN.
- Defined:
  - stall_cnt increments each cycle with out_valid & ~out_ready.
  - bubble_cnt increments each cycle with ~out_valid & out_ready.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: no counter logic; stall_cnt and bubble_cnt are tied to 0. The port list is identical in both builds.

Test Plan:
- WIDTH=64, DEPTH=4, out_ready=1, stream 0x10,0x11,0x12 on consecutive cycles -> out_data shows 0x10,0x11,0x12 on 3 consecutive cycles, with the first appearing 3 cycles after acceptance; occupancy peaks at 3.
- Fill 4 items with out_ready=0 -> in_ready=0 and occupancy=4. Raise out_ready for 1 cycle -> exactly one item emitted, in_ready=1 that cycle, occupancy stays 4 if in_valid=1.
- Items in stages 0 and 2 only, out_ready=0 for 3 cycles -> both compact to stages 3 and 2, with order preserved.
- flush_mask=4'b0110 with all 4 stages valid, out_ready=1 -> only the items from stages 0 and 3 emerge; occupancy drops by 2.
- rst pulsed low mid-stream, asynchronously between edges -> out_valid=0, out_data=0 and occupancy=0 immediately; first post-reset item emerges after normal latency.
- PERF_EN defined: 5 cycles with out_valid=1 and out_ready=0, then 2 idle cycles with out_ready=1 -> stall_cnt=5, bubble_cnt=2. Undefined -> both read 0.

Source files
------------

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: DEPTH-stage pipeline register chain with valid/ready
// handshake, per-stage flush and bubble collapsing.
//
// Optional build macro: PIPE_REG_CHAIN_PERF_EN
//   defined   -> stall_cnt / bubble_cnt are live saturating perf counters
//   undefined -> both counters are tied to zero (same port list)
//
// Handshake: a transfer happens on a rising edge when valid and ready are
// both high at that edge. in_ready may depend combinationally on out_ready
// and on the registered stage valids, never on in_valid. Once out_valid is
// high it stays high with stable out_data until the item is taken
// (out_ready=1) or killed by flush_mask[DEPTH-1].
module pipe_reg_chain #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic [DEPTH-1:0] flush_mask,
    output logic [CW-1:0]    occupancy,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      bubble_cnt
);

    // Stage state: index 0 is the input side, DEPTH-1 drives the output.
    logic [DEPTH-1:0]            r_v;
    logic [DEPTH-1:0][WIDTH-1:0] r_d;
    logic [CW-1:0]               r_occ;

    // Combinational helpers.
    logic [DEPTH-1:0]            w_rdy;
    logic [DEPTH-1:0]            w_v_src;
    logic [DEPTH-1:0][WIDTH-1:0] w_d_src;
    logic [DEPTH-1:0]            w_v_nxt;
    logic [DEPTH-1:0][WIDTH-1:0] w_d_nxt;
    logic [CW-1:0]               w_occ_nxt;

    // Number of set bits in a stage-valid vector.
    function automatic logic [CW-1:0] popcnt(input logic [DEPTH-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    // Ready ripples from the output back to the input; an empty stage is
    // always ready, which is what lets bubbles collapse under back-pressure.
    // Pre-flush valids are used on purpose so a flush never raises ready
    // in the same cycle.
    always_comb begin
        logic acc;
        w_rdy = '0;
        acc   = out_ready | ~r_v[DEPTH-1];
        w_rdy[DEPTH-1] = acc;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            acc      = acc | ~r_v[i];
            w_rdy[i] = acc;
        end
    end

    // Source of each stage: upstream input for stage 0, otherwise the
    // predecessor with its flush bit applied (a flushed item never moves on).
    always_comb begin
        w_v_src    = '0;
        w_d_src    = '0;
        w_v_src[0] = in_valid;
        w_d_src[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            w_v_src[i] = r_v[i-1] & ~flush_mask[i-1];
            w_d_src[i] = r_d[i-1];
        end
    end

    // Next-state per stage: load from the source when ready, otherwise hold
    // and apply the stage's own flush bit. Data only changes when a valid
    // item arrives so idle stages do not toggle the wide payload.
    always_comb begin
        w_v_nxt = '0;
        w_d_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_rdy[i]) begin
                w_v_nxt[i] = w_v_src[i];
                w_d_nxt[i] = w_v_src[i] ? w_d_src[i] : r_d[i];
            end else begin
                w_v_nxt[i] = r_v[i] & ~flush_mask[i];
                w_d_nxt[i] = r_d[i];
            end
        end
    end

    // Occupancy tracks the valid count of the next state so it lands on
    // the same edge as the valids themselves.
    always_comb begin
        w_occ_nxt = popcnt(w_v_nxt);
    end

    // Stage registers; an asynchronous reset discards every in-flight item.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v   <= '0;
            r_d   <= '0;
            r_occ <= '0;
        end else begin
            r_v   <= w_v_nxt;
            r_d   <= w_d_nxt;
            r_occ <= w_occ_nxt;
        end
    end

    assign in_ready  = w_rdy[0];
    assign out_valid = r_v[DEPTH-1];
    assign out_data  = r_d[DEPTH-1];
    assign occupancy = r_occ;

`ifdef PIPE_REG_CHAIN_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;

    // Saturating counters: stall = item waiting at the output, bubble =
    // downstream ready but nothing to give it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (r_v[DEPTH-1] && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (!r_v[DEPTH-1] && out_ready && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

    // Occupancy can never exceed the number of stages.
    a_occ_range : assert property (@(posedge clk) disable iff (!rst)
        occupancy <= CW'(DEPTH));

    // The registered count always agrees with the registered valids.
    a_occ_match : assert property (@(posedge clk) disable iff (!rst)
        occupancy == popcnt(r_v));

    // An offered output item that is neither taken nor flushed stays put.
    a_out_hold : assert property (@(posedge clk) disable iff (!rst)
        (out_valid && !out_ready && !flush_mask[DEPTH-1])
            |=> (out_valid && $stable(out_data)));

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain: a DEPTH=4/WIDTH=64 instance for the
// main scenarios and a DEPTH=1/WIDTH=8 instance for the single-stage case.
module tb_pipe_reg_chain;

    localparam int W  = 64;
    localparam int D  = 4;
    localparam int C  = $clog2(D + 1);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Main instance signals
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data  = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic [D-1:0] flush_mask = '0;
    logic [C-1:0] occupancy;
    logic [31:0]  stall_cnt;
    logic [31:0]  bubble_cnt;

    // Single-stage instance signals
    logic         d1_in_valid  = 1'b0;
    logic         d1_in_ready;
    logic [7:0]   d1_in_data   = '0;
    logic         d1_out_valid;
    logic         d1_out_ready = 1'b0;
    logic [7:0]   d1_out_data;
    logic [0:0]   d1_flush     = '0;
    logic [0:0]   d1_occ;
    logic [31:0]  d1_stall;
    logic [31:0]  d1_bubble;

    int n_vec = 0;
    int n_err = 0;

    pipe_reg_chain #(.WIDTH(W), .DEPTH(D)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .flush_mask (flush_mask),
        .occupancy  (occupancy),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    pipe_reg_chain #(.WIDTH(8), .DEPTH(1)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (d1_in_valid),
        .in_ready   (d1_in_ready),
        .in_data    (d1_in_data),
        .out_valid  (d1_out_valid),
        .out_ready  (d1_out_ready),
        .out_data   (d1_out_data),
        .flush_mask (d1_flush),
        .occupancy  (d1_occ),
        .stall_cnt  (d1_stall),
        .bubble_cnt (d1_bubble)
    );

    // ---------------- driver tasks ----------------
    // Advance one clock; return 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset low between edges with all inputs idle.
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst          = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        out_ready    = 1'b0;
        flush_mask   = '0;
        d1_in_valid  = 1'b0;
        d1_in_data   = '0;
        d1_out_ready = 1'b0;
        d1_flush     = '0;
        #4;
        rst = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(posedge clk);
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_vec++; if (out_data !== 64'h0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_vec++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_vec++; if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
        n_vec++; if (bubble_cnt !== 32'd0) begin n_err++; $display("FAIL reset_bubble_cnt: got %0d want 0", bubble_cnt); end
        n_vec++; if (d1_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_d1_out_valid: got %b want 0", d1_out_valid); end
    endtask

    task automatic test_stream();
        int          exp_occ [7] = '{1, 2, 3, 3, 2, 1, 0};
        logic        exp_ov  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [63:0] exp_od  [7] = '{64'h0, 64'h0, 64'h0, 64'h10, 64'h11, 64'h12, 64'h0};
        int          peak = 0;
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            in_valid = (k < 3);
            in_data  = (k < 3) ? 64'(32'h10 + k) : 64'h0;
            step();
            if (int'(occupancy) > peak) peak = int'(occupancy);
            n_vec++; if (occupancy !== C'(exp_occ[k])) begin n_err++; $display("FAIL stream_occ[%0d]: got %0d want %0d", k, occupancy, exp_occ[k]); end
            n_vec++; if (out_valid !== exp_ov[k]) begin n_err++; $display("FAIL stream_ov[%0d]: got %b want %b", k, out_valid, exp_ov[k]); end
            if (exp_ov[k]) begin
                n_vec++; if (out_data !== exp_od[k]) begin n_err++; $display("FAIL stream_od[%0d]: got %h want %h", k, out_data, exp_od[k]); end
            end
        end
        n_vec++; if (peak != 3) begin n_err++; $display("FAIL stream_peak_occ: got %0d want 3", peak); end
        in_valid = 1'b0;
    endtask

    task automatic test_full_stall();
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = 64'(32'h20 + k);
            step();
        end
        in_data = 64'h24;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
        n_vec++; if (occupancy !== 3'd4) begin n_err++; $display("FAIL full_occ: got %0d want 4", occupancy); end
        n_vec++; if (out_data !== 64'h20) begin n_err++; $display("FAIL full_head: got %h want 20", out_data); end
        step();
        n_vec++; if (occupancy !== 3'd4) begin n_err++; $display("FAIL full_hold_occ: got %0d want 4", occupancy); end
        n_vec++; if (out_data !== 64'h20) begin n_err++; $display("FAIL full_hold_head: got %h want 20", out_data); end
        out_ready = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL full_pass_in_ready: got %b want 1", in_ready); end
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        n_vec++; if (occupancy !== 3'd4) begin n_err++; $display("FAIL full_pass_occ: got %0d want 4", occupancy); end
        n_vec++; if (out_data !== 64'h21) begin n_err++; $display("FAIL full_pass_head: got %h want 21", out_data); end
        step();
        n_vec++; if (out_data !== 64'h21) begin n_err++; $display("FAIL full_one_only: got %h want 21", out_data); end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_vec++; if (out_valid !== 1'b1 || out_data !== 64'(32'h22 + k)) begin n_err++; $display("FAIL full_drain[%0d]: got v=%b %h want v=1 %h", k, out_valid, out_data, 64'(32'h22 + k)); end
        end
        step();
        n_vec++; if (out_valid !== 1'b0 || occupancy !== 3'd0) begin n_err++; $display("FAIL full_empty: got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy); end
    endtask

    task automatic test_compact();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'h30; step();
        in_valid = 1'b0;                   step();
        in_valid = 1'b1; in_data = 64'h31; step();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) step();
        n_vec++; if (occupancy !== 3'd2) begin n_err++; $display("FAIL compact_occ: got %0d want 2", occupancy); end
        n_vec++; if (out_valid !== 1'b1 || out_data !== 64'h30) begin n_err++; $display("FAIL compact_head: got v=%b %h want v=1 30", out_valid, out_data); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL compact_in_ready: got %b want 1", in_ready); end
        out_ready = 1'b1;
        step();
        n_vec++; if (out_valid !== 1'b1 || out_data !== 64'h31) begin n_err++; $display("FAIL compact_second: got v=%b %h want v=1 31", out_valid, out_data); end
        step();
        n_vec++; if (out_valid !== 1'b0 || occupancy !== 3'd0) begin n_err++; $display("FAIL compact_empty: got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy); end
    endtask

    task automatic test_flush();
        logic [W-1:0] exp_q[$];
        logic [W-1:0] e;
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = 64'(32'h40 + k);
            step();
        end
        // Stages now: s3=40 s2=41 s1=42 s0=43; kill s1 and s2 while a new item arrives.
        flush_mask = 4'b0110;
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        in_data    = 64'h44;
        exp_q.push_back(64'h40);
        exp_q.push_back(64'h43);
        exp_q.push_back(64'h44);
        for (int c = 0; c < 10; c++) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++; $display("FAIL flush_extra: got %h want none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    n_vec++; if (out_data !== e) begin n_err++; $display("FAIL flush_order: got %h want %h", out_data, e); end
                end
            end
            step();
            if (c == 0) begin
                n_vec++; if (occupancy !== 3'd2) begin n_err++; $display("FAIL flush_occ: got %0d want 2", occupancy); end
                flush_mask = '0;
                in_valid   = 1'b0;
            end
        end
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL flush_missing: got %0d left want 0", exp_q.size()); end
        n_vec++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL flush_final_occ: got %0d want 0", occupancy); end
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = 64'(32'h50 + k);
            step();
        end
        n_vec++; if (out_valid !== 1'b1 || out_data !== 64'h50) begin n_err++; $display("FAIL arst_pre: got v=%b %h want v=1 50", out_valid, out_data); end
        #2;
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_out_valid: got %b want 0", out_valid); end
        n_vec++; if (out_data !== 64'h0) begin n_err++; $display("FAIL arst_out_data: got %h want 0", out_data); end
        n_vec++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL arst_occ: got %0d want 0", occupancy); end
        #2;
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 64'h55;
        step();
        in_valid = 1'b0;
        step();
        step();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_early: got %b want 0", out_valid); end
        step();
        n_vec++; if (out_valid !== 1'b1 || out_data !== 64'h55) begin n_err++; $display("FAIL arst_latency: got v=%b %h want v=1 55", out_valid, out_data); end
        n_vec++; if (occupancy !== 3'd1) begin n_err++; $display("FAIL arst_occ_after: got %0d want 1", occupancy); end
    endtask

    task automatic test_depth1();
        do_reset();
        d1_in_valid  = 1'b1;
        d1_in_data   = 8'hAB;
        d1_out_ready = 1'b0;
        step();
        d1_in_data = 8'hCD;
        n_vec++; if (d1_out_valid !== 1'b1 || d1_out_data !== 8'hAB) begin n_err++; $display("FAIL d1_load: got v=%b %h want v=1 ab", d1_out_valid, d1_out_data); end
        n_vec++; if (d1_occ !== 1'b1) begin n_err++; $display("FAIL d1_occ_full: got %0d want 1", d1_occ); end
        n_vec++; if (d1_in_ready !== 1'b0) begin n_err++; $display("FAIL d1_in_ready_stall: got %b want 0", d1_in_ready); end
        step();
        n_vec++; if (d1_out_data !== 8'hAB) begin n_err++; $display("FAIL d1_hold: got %h want ab", d1_out_data); end
        d1_out_ready = 1'b1;
        #1;
        n_vec++; if (d1_in_ready !== 1'b1) begin n_err++; $display("FAIL d1_in_ready_pass: got %b want 1", d1_in_ready); end
        step();
        n_vec++; if (d1_out_valid !== 1'b1 || d1_out_data !== 8'hCD || d1_occ !== 1'b1) begin n_err++; $display("FAIL d1_pass: got v=%b %h occ=%0d want v=1 cd occ=1", d1_out_valid, d1_out_data, d1_occ); end
        d1_in_valid  = 1'b0;
        d1_out_ready = 1'b0;
        d1_flush     = 1'b1;
        step();
        d1_flush = 1'b0;
        n_vec++; if (d1_out_valid !== 1'b0 || d1_occ !== 1'b0) begin n_err++; $display("FAIL d1_flush: got v=%b occ=%0d want v=0 occ=0", d1_out_valid, d1_occ); end
    endtask

    task automatic test_perf();
        logic [31:0] exp_stall;
        logic [31:0] exp_bubble;
`ifdef PIPE_REG_CHAIN_PERF_EN
        exp_stall  = 32'd5;
        exp_bubble = 32'd2;
`else
        exp_stall  = 32'd0;
        exp_bubble = 32'd0;
`endif
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hA5;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) step();
        n_vec++; if (out_valid !== 1'b1 || out_data !== 64'hA5) begin n_err++; $display("FAIL perf_arrive: got v=%b %h want v=1 a5", out_valid, out_data); end
        n_vec++; if (stall_cnt !== 32'd0 || bubble_cnt !== 32'd0) begin n_err++; $display("FAIL perf_quiet: got s=%0d b=%0d want s=0 b=0", stall_cnt, bubble_cnt); end
        for (int k = 0; k < 5; k++) step();
        n_vec++; if (stall_cnt !== exp_stall) begin n_err++; $display("FAIL perf_stall_mid: got %0d want %0d", stall_cnt, exp_stall); end
        out_ready = 1'b1;
        step();
        step();
        step();
        out_ready = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL perf_drained: got %b want 0", out_valid); end
        n_vec++; if (stall_cnt !== exp_stall) begin n_err++; $display("FAIL perf_stall: got %0d want %0d", stall_cnt, exp_stall); end
        n_vec++; if (bubble_cnt !== exp_bubble) begin n_err++; $display("FAIL perf_bubble: got %0d want %0d", bubble_cnt, exp_bubble); end
    endtask

    // ---------------- sequence + final report ----------------
    initial begin
        test_reset();
        test_stream();
        test_full_stall();
        test_compact();
        test_flush();
        test_async_reset();
        test_depth1();
        test_perf();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog: the scenarios above are bounded, this only guards a hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
